ternary_mvm_stream: RTL and testbench
=====================================

TERNARY_MVM_STREAM -- requirements
Module: ternary_mvm_stream

Interface
REQ-001 SHALL have parameter IN_LEN, default 16: input vector length (elements per frame).
REQ-002 SHALL have parameter OUT_LEN, default 8: output vector length (matrix columns).
REQ-003 SHALL have parameter IN_W, default 8: signed input element width.
REQ-004 SHALL have parameter LANES, default 2: input elements accepted per beat; IN_LEN % LANES == 0 is required.
REQ-005 SHALL have parameter OUT_W, default 8: signed output element width.
REQ-006 SHALL have port clk, input, 1 bit: clock, all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port w, input, 2*IN_LEN*OUT_LEN bits: ternary weights, held stable for a whole frame.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data beat valid.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-011 SHALL have port in_data, input, LANES*IN_W bits: lane 0 in the LSBs, two's complement.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-013 SHALL have port out_ready, input, 1 bit: sink accepts the output word.
REQ-014 SHALL have port out_data, output, OUT_W bits: result element.
REQ-015 SHALL have port out_idx, output, clog2(OUT_LEN) bits: index of the current out_data word.
REQ-016 SHALL have port out_last, output, 1 bit: high together with the word at out_idx == OUT_LEN-1.

Function
REQ-017 SHALL decode each weight as {neg,nz}: 01 = +1, 11 = -1, 00 or 10 = 0.
REQ-018 SHALL locate the weight for input j, output i at w bits [2*(j*OUT_LEN+i) +: 2].
REQ-019 SHALL map beat k, lane l to input index j = k*LANES + l.
REQ-020 SHALL implement a 2-state FSM: ACCUM (in_ready=1, out_valid=0) and DRAIN (in_ready=0, out_valid=1).
REQ-021 SHALL, in ACCUM on each in_valid&in_ready, add sign-extended ±x or 0 for every lane into all OUT_LEN accumulators and increment the beat counter.
REQ-022 SHALL size accumulators at IN_W+clog2(IN_LEN)+1 bits so that no accumulation overflow is possible.
REQ-023 SHALL leave accumulators and counter unchanged on cycles without an accepted beat.
REQ-024 SHALL, on acceptance of beat IN_LEN/LANES-1, move the final sums (including that beat) into the output buffer, clear the accumulators, and enter DRAIN next cycle; first out_valid follows one cycle after the last beat is accepted.
REQ-025 SHALL, in DRAIN, present words in order out_idx 0..OUT_LEN-1, advancing only on out_valid&out_ready.
REQ-026 SHALL hold out_data, out_idx and out_last stable while out_valid=1 and out_ready=0.
REQ-027 SHALL return to ACCUM the cycle after the out_last word is accepted; in_ready is 1 on that next cycle.
REQ-028 SHALL never accept in_data while in DRAIN.
REQ-029 SHALL, by default, output the low OUT_W bits of the accumulator (two's complement wrap).

Reset
REQ-030 SHALL, while rst_n=0 at a clk edge, set the state to ACCUM, counters to 0, accumulators and output buffer to 0, out_valid=0, out_data=0, out_idx=0 and out_last=0.
REQ-031 SHALL hold in_ready=0 during any cycle with rst_n=0.
REQ-032 SHALL discard a partial frame or pending drain on reset; the next frame result depends only on post-reset beats.

Configuration
REQ-033 SHALL, with TERNARY_MVM_SAT_EN defined, saturate each output to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; without the macro, SHALL wrap per REQ-029.

Structure
REQ-034 SHALL take the weight-encoding constants (W_ZERO, W_POS, W_NEG), the state type and a clog2 helper from shared package ternary_pkg.
REQ-035 SHALL instantiate one sub-module ternary_pe per output, performing the LANES-wide ternary select/sum and accumulator update.

Verification (IN_LEN=16, OUT_LEN=8, LANES=2, IN_W=OUT_W=8)
REQ-036 SHALL cover: all weights 01, all inputs 1 -> eight words of 0x10, out_idx 0..7, out_last on idx 7.
REQ-037 SHALL cover: all weights 11, inputs 3 -> every word 0xD0 (-48).
REQ-038 SHALL cover: weights alternating 00/10, any inputs -> all words 0x00.
REQ-039 SHALL cover: all weights 01, inputs 127 -> 0x7F with TERNARY_MVM_SAT_EN, 0xF0 without it.
REQ-040 SHALL cover: random in_valid gaps plus out_ready low for 5 cycles at idx 3 -> outputs held stable, in_ready 0 throughout DRAIN, results identical to the gap-free run.
REQ-041 SHALL cover: rst_n low for 1 cycle after 3 beats, followed by a full frame of test REQ-036 -> all words 0x10.

Source files
------------

// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary matrix-vector streaming block.
package ternary_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;

  typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ternary_pe.sv
// One output column: LANES-wide ternary select/sum into a wide accumulator.
module ternary_pe import ternary_pkg::*; #(
  parameter int LANES = 2,
  parameter int IN_W  = 8,
  parameter int ACC_W = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic [LANES*IN_W-1:0]  i_x,
  input  logic [2*LANES-1:0]     i_w,
  output logic [ACC_W-1:0]       o_sum
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_sum;

  always_comb begin
    logic signed [ACC_W-1:0] xe;
    w_sum = r_acc;
    xe    = '0;
    for (int l = 0; l < LANES; l++) begin
      xe = {{(ACC_W-IN_W){i_x[l*IN_W+IN_W-1]}}, i_x[l*IN_W +: IN_W]};
      // nz=0 codes (00, 10) contribute nothing
      case (i_w[2*l +: 2])
        W_POS:   w_sum = w_sum + xe;
        W_NEG:   w_sum = w_sum - xe;
        default: w_sum = w_sum;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    r_acc <= '0;
    else if (i_en) r_acc <= i_clr ? '0 : w_sum;
  end

  assign o_sum = w_sum;

endmodule

// File: rtl/ternary_mvm_stream.sv
// Streaming ternary matrix-vector multiply: accumulate a frame, then drain OUT_LEN words.
// Define TERNARY_MVM_SAT_EN to saturate outputs instead of wrapping.
module ternary_mvm_stream import ternary_pkg::*; #(
  parameter int IN_LEN  = 16,
  parameter int OUT_LEN = 8,
  parameter int IN_W    = 8,
  parameter int LANES   = 2,
  parameter int OUT_W   = 8,
  localparam int IDX_W  = (OUT_LEN > 1) ? clog2(OUT_LEN) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2*IN_LEN*OUT_LEN-1:0] w,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*IN_W-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_last
);

  localparam int ACC_W  = IN_W + clog2(IN_LEN) + 1;
  localparam int NBEATS = IN_LEN / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? clog2(NBEATS) : 1;

`ifdef TERNARY_MVM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
`endif

  function automatic logic [OUT_W-1:0] fmt(input logic signed [ACC_W-1:0] a);
`ifdef TERNARY_MVM_SAT_EN
    if (a > SAT_HI)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (a < SAT_LO) return {1'b1, {(OUT_W-1){1'b0}}};
    else                 return a[OUT_W-1:0];
`else
    return a[OUT_W-1:0];
`endif
  endfunction

  state_t                            r_state, w_nxt;
  logic [BEAT_W-1:0]                 r_beat;
  logic [IDX_W-1:0]                  r_idx;
  logic [OUT_LEN-1:0][OUT_W-1:0]     r_buf;
  logic [OUT_LEN-1:0][ACC_W-1:0]     w_sum;
  logic [OUT_LEN-1:0][2*LANES-1:0]   w_pw;
  logic                              w_beat, w_last_beat, w_take, w_last_word;

  assign w_beat      = in_valid & in_ready;
  assign w_last_beat = w_beat & (r_beat == BEAT_W'(NBEATS-1));
  assign w_take      = out_valid & out_ready;
  assign w_last_word = w_take & (r_idx == IDX_W'(OUT_LEN-1));

  // Weight slice for (beat, lane, column) selected by the beat counter
  for (genvar i = 0; i < OUT_LEN; i++) begin : g_col
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_pw[i][2*l +: 2] = w[2*((int'(r_beat)*LANES + l)*OUT_LEN + i) +: 2];
    end
    ternary_pe #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) u_pe (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_beat),
      .i_clr (w_last_beat),
      .i_x   (in_data),
      .i_w   (w_pw[i]),
      .o_sum (w_sum[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = rst_n;
        if (w_last_beat) w_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (w_last_word) w_nxt = ACCUM;
      end
      default: w_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_idx  <= '0;
      r_buf  <= '0;
    end else begin
      if (w_beat) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      if (w_last_beat)
        for (int i = 0; i < OUT_LEN; i++) r_buf[i] <= fmt(w_sum[i]);
      if (w_take) r_idx <= w_last_word ? '0 : r_idx + 1'b1;
    end
  end

  assign out_data = out_valid ? r_buf[r_idx] : '0;
  assign out_idx  = r_idx;
  assign out_last = out_valid & (r_idx == IDX_W'(OUT_LEN-1));

endmodule

// File: tb/tb_ternary_mvm_stream.sv
// Scoreboard bench: directed frames push expected words, a negedge monitor pops and compares.
module tb_ternary_mvm_stream;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] w = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [7:0]   out_data;
  logic [2:0]   out_idx;
  logic         out_last;

  ternary_mvm_stream #(.IN_LEN(16), .OUT_LEN(8), .IN_W(8), .LANES(2), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .w(w),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [11:0] q[$];        // {last, idx, data}
  logic [7:0] xv[16];
  int         stall_at = -1;
  int         stall_cnt = 0;
  bit         after_last = 0;
  bit         held_v = 0;
  logic [11:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Sink: stall out_ready for 5 cycles when the chosen index shows up
  always begin
    @(posedge clk); #1;
    if (!out_valid) stall_cnt = 0;
    if (stall_at >= 0 && out_valid && int'(out_idx) == stall_at && stall_cnt < 5) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else out_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (after_last) begin
        chk("in_ready_after_last", {31'b0, in_ready}, 32'd1);
        chk("out_valid_after_last", {31'b0, out_valid}, 32'd0);
        after_last = 0;
      end
      if (out_valid) chk("in_ready_in_drain", {31'b0, in_ready}, 32'd0);
      if (out_valid && !out_ready) begin
        if (held_v) chk("hold_stable", {20'b0, out_last, out_idx, out_data}, {20'b0, held});
        held   = {out_last, out_idx, out_data};
        held_v = 1;
      end else held_v = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_word", {20'b0, out_last, out_idx, out_data}, 32'hFFFF);
        else chk("out_word", {20'b0, out_last, out_idx, out_data}, {20'b0, q.pop_front()});
        if (out_last) after_last = 1;
      end
    end else begin
      held_v = 0;
      after_last = 0;
    end
  end

  task automatic push_word(input int idx, input logic [7:0] d);
    q.push_back({(idx == 7), 3'(idx), d});
  endtask

  task automatic push_all(input logic [7:0] d);
    for (int i = 0; i < 8; i++) push_word(i, d);
  endtask

  task automatic set_x(input logic [7:0] v);
    for (int j = 0; j < 16; j++) xv[j] = v;
  endtask

  task automatic send_beats(input int nb, input bit gaps);
    bit acc;
    int t;
    for (int k = 0; k < nb; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = {xv[2*k+1], xv[2*k]};
      acc = 0;
      t   = 0;
      while (!acc && t < 100) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) chk("beat_accept_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((q.size() != 0 || out_valid) && t < 300);
    if (t >= 300) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {24'b0, out_data}, 32'd0);
    chk("rst_out_idx", {29'b0, out_idx}, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // All +1, inputs 1 -> 16
    w = {128{2'b01}}; set_x(8'd1); push_all(8'h10);
    send_beats(8, 0); wait_drain();

    // All -1, inputs 3 -> -48
    w = {128{2'b11}}; set_x(8'd3); push_all(8'hD0);
    send_beats(8, 0); wait_drain();

    // Zero codes 00 / 10 -> 0
    w = {64{2'b10, 2'b00}};
    for (int j = 0; j < 16; j++) xv[j] = 8'(j * 37 + 5);
    push_all(8'h00);
    send_beats(8, 0); wait_drain();

    // Index mapping: out i = x[i] - (i odd ? x[15] : 0), x[j] = j
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[2*(i*8+i) +: 2] = 2'b01;
      if (i % 2 == 1) w[2*(15*8+i) +: 2] = 2'b11;
    end
    for (int j = 0; j < 16; j++) xv[j] = 8'(j);
    push_word(0, 8'h00); push_word(1, 8'hF2); push_word(2, 8'h02); push_word(3, 8'hF4);
    push_word(4, 8'h04); push_word(5, 8'hF6); push_word(6, 8'h06); push_word(7, 8'hF8);
    send_beats(8, 0); wait_drain();

    // Overflow of the output word: 16*127 = 2032
    w = {128{2'b01}}; set_x(8'd127);
`ifdef TERNARY_MVM_SAT_EN
    push_all(8'h7F);
`else
    push_all(8'hF0);
`endif
    send_beats(8, 0); wait_drain();

    // Input gaps plus a 5-cycle sink stall at idx 3
    stall_at = 3;
    w = {128{2'b01}}; set_x(8'd1); push_all(8'h10);
    send_beats(8, 1); wait_drain();
    stall_at = -1;

    // Reset mid-frame discards partial sums
    set_x(8'd5);
    send_beats(3, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_x(8'd1); push_all(8'h10);
    send_beats(8, 0); wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
